// File: rtl/popcnt_accum.sv
// Burst accumulator behind the 32-bit popcount unit: sums per-word counts and words per burst.
// Optional PRIMARY_MAXCNT_EN adds out_max, the largest effective per-word count of the burst.
module popcnt_accum #(
   parameter int SUM_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_count,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_words,
   output logic             out_sat,
   output logic             out_err
`ifdef PRIMARY_MAXCNT_EN
   ,
   output logic [5:0]       out_max
`endif
);

   localparam logic [0:0] ACC = 1'b0;
   localparam logic [0:0] OUT = 1'b1;

   logic [0:0]       state;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] words;
   logic             sat;
   logic             err;

   logic             accept;
   logic             illegal;
   logic [5:0]       c;
   logic [SUM_W:0]   sum_wide;
   logic [CNT_W:0]   words_wide;
   logic [SUM_W-1:0] sum_nxt;
   logic [CNT_W-1:0] words_nxt;
   logic             sum_clamp;
   logic             words_clamp;

   assign accept = in_valid && (state == ACC);

   // One extra carry bit on each adder detects overflow; clamp to all-ones.
   always_comb begin
      illegal     = (in_count > 6'd32);
      c           = illegal ? 6'd32 : in_count;
      sum_wide    = {1'b0, sum} + {{(SUM_W + 1 - 6){1'b0}}, c};
      words_wide  = {1'b0, words} + {{CNT_W{1'b0}}, 1'b1};
      sum_clamp   = sum_wide[SUM_W];
      words_clamp = words_wide[CNT_W];
      sum_nxt     = sum_clamp ? '1 : sum_wide[SUM_W-1:0];
      words_nxt   = words_clamp ? '1 : words_wide[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ACC;
         sum   <= '0;
         words <= '0;
         sat   <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (accept) begin
                  sum   <= sum_nxt;
                  words <= words_nxt;
                  sat   <= sat | sum_clamp | words_clamp;
                  err   <= err | illegal;
                  if (in_last)
                     state <= OUT;
               end
            end
            default: begin
               if (out_ready) begin
                  state <= ACC;
                  sum   <= '0;
                  words <= '0;
                  sat   <= 1'b0;
                  err   <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef PRIMARY_MAXCNT_EN
   logic [5:0] maxc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         maxc <= '0;
      end else if (accept) begin
         if (c > maxc)
            maxc <= c;
      end else if ((state == OUT) && out_ready) begin
         maxc <= '0;
      end
   end

   assign out_max = maxc;
`endif

   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);
   assign out_sum   = sum;
   assign out_words = words;
   assign out_sat   = sat;
   assign out_err   = err;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: default-width DUT plus a SUM_W=6 copy driven in lockstep,
// results checked against a bench-side model through a scoreboard queue.
module tb_popcnt_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       in_valid;
   logic [5:0] in_count;
   logic       in_last;
   logic       out_ready;

   logic        in_ready_a, out_valid_a, sat_a, err_a;
   logic [15:0] sum_a, words_a;
   logic        in_ready_b, out_valid_b, sat_b, err_b;
   logic [5:0]  sum_b;
   logic [15:0] words_b;
`ifdef PRIMARY_MAXCNT_EN
   logic [5:0]  max_a, max_b;
`endif

   popcnt_accum #(.SUM_W(16), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_count(in_count), .in_last(in_last), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_sum(sum_a), .out_words(words_a),
      .out_sat(sat_a), .out_err(err_a)
`ifdef PRIMARY_MAXCNT_EN
      , .out_max(max_a)
`endif
   );

   popcnt_accum #(.SUM_W(6), .CNT_W(16)) u_dut6 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_count(in_count), .in_last(in_last), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_sum(sum_b), .out_words(words_b),
      .out_sat(sat_b), .out_err(err_b)
`ifdef PRIMARY_MAXCNT_EN
      , .out_max(max_b)
`endif
   );

   typedef struct {
      int unsigned sum_a;
      int unsigned sum_b;
      int unsigned words;
      bit          sat_a;
      bit          sat_b;
      bit          err;
      int unsigned mx;
   } exp_t;

   exp_t sb[$];

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   int unsigned m_sum_a, m_sum_b, m_words, m_mx;
   bit          m_sat_a, m_sat_b, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_sum_a = 0; m_sum_b = 0; m_words = 0; m_mx = 0;
      m_sat_a = 0; m_sat_b = 0; m_err = 0;
   endtask

   task automatic model_beat(input int unsigned cnt);
      int unsigned c;
      c = (cnt > 32) ? 32 : cnt;
      if (cnt > 32) m_err = 1;
      if (m_sum_a + c > 65535) begin m_sum_a = 65535; m_sat_a = 1; end
      else m_sum_a = m_sum_a + c;
      if (m_sum_b + c > 63) begin m_sum_b = 63; m_sat_b = 1; end
      else m_sum_b = m_sum_b + c;
      if (m_words + 1 > 65535) begin m_words = 65535; m_sat_a = 1; m_sat_b = 1; end
      else m_words = m_words + 1;
      if (c > m_mx) m_mx = c;
   endtask

   task automatic send(input int unsigned cnt, input bit last);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_count = cnt[5:0];
      in_last  = last;
      chk("in_ready_a", {31'b0, in_ready_a}, 1);
      chk("in_ready_b", {31'b0, in_ready_b}, 1);
      @(posedge clk);
      model_beat(cnt);
      if (last) begin
         e.sum_a = m_sum_a; e.sum_b = m_sum_b; e.words = m_words;
         e.sat_a = m_sat_a; e.sat_b = m_sat_b; e.err = m_err; e.mx = m_mx;
         sb.push_back(e);
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_valid"}, {31'b0, out_valid_a}, 0);
      chk({tag, "_ready"}, {31'b0, in_ready_a}, 1);
      chk({tag, "_sum_a"}, {16'b0, sum_a}, 0);
      chk({tag, "_sum_b"}, {26'b0, sum_b}, 0);
      chk({tag, "_words"}, {16'b0, words_a}, 0);
      chk({tag, "_sat"}, {30'b0, sat_a, sat_b}, 0);
      chk({tag, "_err"}, {30'b0, err_a, err_b}, 0);
`ifdef PRIMARY_MAXCNT_EN
      chk({tag, "_max"}, {26'b0, max_a}, 0);
`endif
   endtask

   // Waits (bounded) for the result, compares it to the scoreboard, holds it for
   // 'hold' cycles with a stray beat offered, then completes the handshake.
   task automatic collect(input string tag, input int unsigned hold);
      exp_t e;
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!out_valid_a && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, 0);
      chk({tag, "_valid_a"}, {31'b0, out_valid_a}, 1);
      chk({tag, "_valid_b"}, {31'b0, out_valid_b}, 1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum_a"}, {16'b0, sum_a}, e.sum_a);
         chk({tag, "_sum_b"}, {26'b0, sum_b}, e.sum_b);
         chk({tag, "_words_a"}, {16'b0, words_a}, e.words);
         chk({tag, "_words_b"}, {16'b0, words_b}, e.words);
         chk({tag, "_sat_a"}, {31'b0, sat_a}, {31'b0, e.sat_a});
         chk({tag, "_sat_b"}, {31'b0, sat_b}, {31'b0, e.sat_b});
         chk({tag, "_err_a"}, {31'b0, err_a}, {31'b0, e.err});
         chk({tag, "_err_b"}, {31'b0, err_b}, {31'b0, e.err});
`ifdef PRIMARY_MAXCNT_EN
         chk({tag, "_max_a"}, {26'b0, max_a}, e.mx);
         chk({tag, "_max_b"}, {26'b0, max_b}, e.mx);
`endif
         for (int i = 0; i < int'(hold); i++) begin
            in_valid = 1'b1;
            in_count = 6'd9;
            in_last  = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'b0, out_valid_a}, 1);
            chk({tag, "_hold_ready"}, {31'b0, in_ready_a}, 0);
            chk({tag, "_hold_sum"}, {16'b0, sum_a}, e.sum_a);
            chk({tag, "_hold_words"}, {16'b0, words_a}, e.words);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      model_clear();
      @(negedge clk);
      check_cleared({tag, "_clr"});
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_count  = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_cleared("reset");
      chk("reset_valid_b", {31'b0, out_valid_b}, 0);

      send(3, 0); send(32, 0); send(0, 1);
      collect("basic", 0);

      send(17, 1);
      collect("hold", 5);

      send(32, 0); send(32, 1);
      collect("satur", 0);

      send(40, 1);
      collect("illegal", 0);
      send(5, 1);
      collect("legal", 0);

      send(10, 0); send(10, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      model_clear();
      @(negedge clk);
      check_cleared("midrst");
      send(4, 1);
      collect("postrst", 0);

      send(7, 0); send(29, 0); send(12, 1);
      collect("max1", 0);
      send(3, 1);
      collect("max2", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
